// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: control strobes between the sequencer (master) and the datapath (slave).
// The datapath supplies the current IR and the memory MFC handshake. The sequencer drives
// every load/drive strobe plus the halted/fault/retire status bits.
interface ctrl_sequencer_if;
   logic [15:0] ir;
   logic        MFC;
   logic [3:0]  G_in;
   logic [3:0]  G_out;
   logic        ALUin1;
   logic        ALUin2;
   logic        ALU_outlach;
   logic        ALU_outEN;
   logic        PC_Out;
   logic        PC_inc;
   logic        P0_in;
   logic        P1_in;
   logic        P1_out;
   logic        MAR_EN;
   logic        MDR_EN_write;
   logic        MDR_EN_read;
   logic        MDR_out;
   logic        IR_EN;
   logic        mem_EN;
   logic        mem_RW;
   logic        halted;
   logic        fault;
   logic        retire;

   modport master (
      input  ir, MFC,
      output G_in, G_out, ALUin1, ALUin2, ALU_outlach, ALU_outEN, PC_Out, PC_inc,
             P0_in, P1_in, P1_out, MAR_EN, MDR_EN_write, MDR_EN_read, MDR_out, IR_EN,
             mem_EN, mem_RW, halted, fault, retire
   );

   modport slave (
      output ir, MFC,
      input  G_in, G_out, ALUin1, ALUin2, ALU_outlach, ALU_outEN, PC_Out, PC_inc,
             P0_in, P1_in, P1_out, MAR_EN, MDR_EN_write, MDR_EN_read, MDR_out, IR_EN,
             mem_EN, mem_RW, halted, fault, retire
   );
endinterface

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: hardwired fetch/decode/execute control unit for the 16-bit bus MCU.
// Strobes are Moore-decoded from the state register and the IR fields.
// Optional feature: define CTRL_MFC_TIMEOUT_EN to enter the fault state after MFC_TIMEOUT
// consecutive memory-wait cycles with MFC low; without it, wait states hold indefinitely.
module ctrl_sequencer
`ifdef CTRL_MFC_TIMEOUT_EN
#(
   parameter int unsigned MFC_TIMEOUT = 15
)
`endif
(
   input logic              clk,
   input logic              rst,
   ctrl_sequencer_if.master dp
);

   typedef enum logic [4:0] {
      StF0, StFrw, StFrl, StF2, StDec,
      StA0, StA1, StA2, StA3,
      StL0, StLrw, StLrl, StL2,
      StS0, StS1, StSww,
      StI0, StI1, StO0,
      StHlt, StFlt
   } state_e;

   state_e     state_q, state_d;
   logic       illegal_q, illegal_d;
   logic       c;
   logic [2:0] op;
   logic [1:0] d, a, b;
   logic       dec_illegal;
   logic       in_wait;

   assign c           = dp.ir[15];
   assign op          = dp.ir[14:12];
   assign d           = dp.ir[11:10];
   assign a           = dp.ir[9:8];
   assign b           = dp.ir[7:6];
   assign dec_illegal = (state_q == StDec) && !c && (op[2:1] == 2'b11);
   assign in_wait     = (state_q == StFrw) || (state_q == StLrw) || (state_q == StSww);

`ifdef CTRL_MFC_TIMEOUT_EN
   localparam int unsigned CntW = ($clog2(MFC_TIMEOUT + 1) > 4) ? $clog2(MFC_TIMEOUT + 1) : 4;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            timeout_hit;

   assign timeout_hit = in_wait && !dp.MFC && (cnt_q == CntW'(MFC_TIMEOUT - 1));
`endif

   // Next-state sequencing; MFC only matters inside the three wait states.
   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q | dec_illegal;
      unique case (state_q)
         StF0:  state_d = StFrw;
         StFrw: if (dp.MFC) state_d = StFrl;
         StFrl: state_d = StF2;
         StF2:  state_d = StDec;
         StDec: begin
            if (c) begin
               state_d = StA0;
            end else begin
               case (op)
                  3'b001:  state_d = StL0;
                  3'b010:  state_d = StS0;
                  3'b011:  state_d = StI0;
                  3'b100:  state_d = StO0;
                  3'b101:  state_d = StHlt;
                  default: state_d = StF0;   // NOP and illegal retire here
               endcase
            end
         end
         StA0:  state_d = StA1;
         StA1:  state_d = StA2;
         StA2:  state_d = StA3;
         StA3:  state_d = StF0;
         StL0:  state_d = StLrw;
         StLrw: if (dp.MFC) state_d = StLrl;
         StLrl: state_d = StL2;
         StL2:  state_d = StF0;
         StS0:  state_d = StS1;
         StS1:  state_d = StSww;
         StSww: if (dp.MFC) state_d = StF0;
         StI0:  state_d = StI1;
         StI1:  state_d = StF0;
         StO0:  state_d = StF0;
         StHlt: state_d = StHlt;
         StFlt: state_d = StFlt;
         default: state_d = StF0;
      endcase
`ifdef CTRL_MFC_TIMEOUT_EN
      // Counter restarts on every entry to a wait state and counts consecutive stall cycles.
      cnt_d = (in_wait && (state_d == state_q)) ? cnt_q + 1'b1 : '0;
      if (timeout_hit) state_d = StFlt;
`endif
   end

   // State, sticky illegal flag and (optional) timeout counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StF0;
         illegal_q <= 1'b0;
`ifdef CTRL_MFC_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
`ifdef CTRL_MFC_TIMEOUT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   // Moore strobe decode; everything is forced low while reset is asserted.
   always_comb begin
      dp.G_in         = 4'b0000;
      dp.G_out        = 4'b0000;
      dp.ALUin1       = 1'b0;
      dp.ALUin2       = 1'b0;
      dp.ALU_outlach  = 1'b0;
      dp.ALU_outEN    = 1'b0;
      dp.PC_Out       = 1'b0;
      dp.PC_inc       = 1'b0;
      dp.P0_in        = 1'b0;
      dp.P1_in        = 1'b0;
      dp.P1_out       = 1'b0;
      dp.MAR_EN       = 1'b0;
      dp.MDR_EN_write = 1'b0;
      dp.MDR_EN_read  = 1'b0;
      dp.MDR_out      = 1'b0;
      dp.IR_EN        = 1'b0;
      dp.mem_EN       = 1'b0;
      dp.mem_RW       = 1'b0;
      dp.halted       = 1'b0;
      dp.fault        = 1'b0;
      dp.retire       = 1'b0;
      if (rst) begin
         dp.fault = illegal_q | dec_illegal | (state_q == StFlt);
         unique case (state_q)
            StF0:  begin dp.PC_Out = 1'b1; dp.MAR_EN = 1'b1; dp.PC_inc = 1'b1; end
            StFrw, StLrw: begin dp.mem_EN = 1'b1; dp.mem_RW = 1'b1; end
            StFrl, StLrl: begin dp.mem_EN = 1'b1; dp.mem_RW = 1'b1; dp.MDR_EN_read = 1'b1; end
            StF2:  begin dp.MDR_out = 1'b1; dp.IR_EN = 1'b1; end
            StDec: dp.retire = !c && ((op == 3'b000) || (op[2:1] == 2'b11));
            StA0:  begin dp.G_out = 4'b0001 << d; dp.ALUin1 = 1'b1; end
            StA1:  begin dp.G_out = 4'b0001 << a; dp.ALUin2 = 1'b1; end
            StA2:  dp.ALU_outlach = 1'b1;
            StA3:  begin dp.ALU_outEN = 1'b1; dp.G_in = 4'b0001 << b; dp.retire = 1'b1; end
            StL0, StS0: begin dp.G_out = 4'b0001 << a; dp.MAR_EN = 1'b1; end
            StL2:  begin dp.MDR_out = 1'b1; dp.G_in = 4'b0001 << d; dp.retire = 1'b1; end
            StS1:  begin dp.G_out = 4'b0001 << d; dp.MDR_EN_write = 1'b1; end
            // The store completes in the cycle MFC arrives, so retire is qualified by it.
            StSww: begin dp.mem_EN = 1'b1; dp.retire = dp.MFC; end
            StI0:  dp.P1_in = 1'b1;
            StI1:  begin dp.P1_out = 1'b1; dp.G_in = 4'b0001 << d; dp.retire = 1'b1; end
            StO0:  begin dp.G_out = 4'b0001 << d; dp.P0_in = 1'b1; dp.retire = 1'b1; end
            StHlt: dp.halted = 1'b1;
            StFlt: ;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed bench for ctrl_sequencer with a minimal IR-latch datapath model.
module tb_ctrl_sequencer;

   logic        clk;
   logic        rst;
   logic [15:0] next_ir;
   int          checks;
   int          failures;
   int          bad;

   ctrl_sequencer_if bus ();

   ctrl_sequencer dut (
      .clk (clk),
      .rst (rst),
      .dp  (bus)
   );

   // Strobe bit positions in the packed observation vector.
   localparam logic [26:0] ALU1 = 27'd1 << 18;
   localparam logic [26:0] ALU2 = 27'd1 << 17;
   localparam logic [26:0] ALUL = 27'd1 << 16;
   localparam logic [26:0] ALUE = 27'd1 << 15;
   localparam logic [26:0] PCO  = 27'd1 << 14;
   localparam logic [26:0] PCI  = 27'd1 << 13;
   localparam logic [26:0] P0I  = 27'd1 << 12;
   localparam logic [26:0] P1I  = 27'd1 << 11;
   localparam logic [26:0] P1O  = 27'd1 << 10;
   localparam logic [26:0] MAR  = 27'd1 << 9;
   localparam logic [26:0] MDRW = 27'd1 << 8;
   localparam logic [26:0] MDRR = 27'd1 << 7;
   localparam logic [26:0] MDRO = 27'd1 << 6;
   localparam logic [26:0] IREN = 27'd1 << 5;
   localparam logic [26:0] MEN  = 27'd1 << 4;
   localparam logic [26:0] MRW  = 27'd1 << 3;
   localparam logic [26:0] HLTD = 27'd1 << 2;
   localparam logic [26:0] FLT  = 27'd1 << 1;
   localparam logic [26:0] RET  = 27'd1 << 0;

   logic [26:0] strobes;
   assign strobes = {bus.G_in, bus.G_out, bus.ALUin1, bus.ALUin2, bus.ALU_outlach,
                     bus.ALU_outEN, bus.PC_Out, bus.PC_inc, bus.P0_in, bus.P1_in, bus.P1_out,
                     bus.MAR_EN, bus.MDR_EN_write, bus.MDR_EN_read, bus.MDR_out, bus.IR_EN,
                     bus.mem_EN, bus.mem_RW, bus.halted, bus.fault, bus.retire};

   function automatic logic [26:0] gin(input logic [3:0] v);
      return {v, 23'd0};
   endfunction

   function automatic logic [26:0] gout(input logic [3:0] v);
      return {4'd0, v, 19'd0};
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath IR register: loads the next instruction word when IR_EN is strobed.
   always @(posedge clk or negedge rst) begin
      if (!rst) bus.ir <= 16'h0000;
      else if (bus.IR_EN) bus.ir <= next_ir;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [26:0] exp);
      checks++;
      assert (strobes === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, strobes, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // F0..F2 with immediate MFC; returns with the sequencer in DEC.
   task automatic fetch(input logic [15:0] instr, input logic [26:0] sticky);
      next_ir = instr;
      check("f0", PCO | MAR | PCI | sticky);
      tick();
      check("frw", MEN | MRW | sticky);
      tick();
      check("frl", MEN | MRW | MDRR | sticky);
      tick();
      check("f2", MDRO | IREN | sticky);
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      bus.MFC  = 1'b1;
      next_ir  = 16'h0000;

      #3;
      check("reset_zero", 27'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;

      // NOP: 5 cycles, retire in DEC
      fetch(16'h0000, 27'd0);
      check("nop_dec", RET);
      tick();

      // ALU op 001: d=G0, a=G1, b=G2; 9 cycles
      fetch(16'h9180, 27'd0);
      check("alu_dec", 27'd0);
      tick();
      check("alu_a0", gout(4'b0001) | ALU1);
      tick();
      check("alu_a1", gout(4'b0010) | ALU2);
      tick();
      check("alu_a2", ALUL);
      tick();
      check("alu_a3", ALUE | gin(4'b0100) | RET);
      tick();

      // LOAD d=1 a=2 with MFC held low for 3 extra LRW cycles: retire 12 cycles after F0
      fetch(16'h1600, 27'd0);
      check("ld_dec", 27'd0);
      tick();
      check("ld_l0", gout(4'b0100) | MAR);
      bus.MFC = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("ld_lrw", MEN | MRW);
      end
      bus.MFC = 1'b1;
      tick();
      check("ld_lrl", MEN | MRW | MDRR);
      tick();
      check("ld_l2", MDRO | gin(4'b0010) | RET);
      tick();

      // STORE d=3 a=1 with one stalled SWW cycle
      fetch(16'h2D00, 27'd0);
      check("st_dec", 27'd0);
      tick();
      check("st_s0", gout(4'b0010) | MAR);
      tick();
      check("st_s1", gout(4'b1000) | MDRW);
      bus.MFC = 1'b0;
      tick();
      check("st_sww_stall", MEN);
      bus.MFC = 1'b1;
      #1;
      check("st_sww_done", MEN | RET);
      tick();

      // IN d=1: 7 cycles
      fetch(16'h3400, 27'd0);
      check("in_dec", 27'd0);
      tick();
      check("in_i0", P1I);
      tick();
      check("in_i1", P1O | gin(4'b0010) | RET);
      tick();

      // OUT d=3: 6 cycles
      fetch(16'h4C00, 27'd0);
      check("out_dec", 27'd0);
      tick();
      check("out_o0", gout(4'b1000) | P0I | RET);
      tick();

      // Illegal opcode: retire at DEC, fault sticky, fetch continues
      fetch(16'h6000, 27'd0);
      check("ill_dec", RET | FLT);
      tick();

      // HALT: no strobes for 100 cycles, fault still sticky
      fetch(16'h5000, FLT);
      check("hlt_dec", FLT);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (strobes !== (HLTD | FLT)) bad++;
      end
      check_int("hlt_hold_bad_cycles", bad, 0);

      // Reset out of HLT clears halted and fault
      rst = 1'b0;
      #1;
      check("rst_from_hlt", 27'd0);
      tick();
      rst = 1'b1;
      #1;

      // Reset asynchronously in the middle of LRW
      fetch(16'h1600, 27'd0);
      tick();
      check("rl_l0", gout(4'b0100) | MAR);
      bus.MFC = 1'b0;
      tick();
      check("rl_lrw", MEN | MRW);
      #2 rst = 1'b0;
      #1;
      check("rst_mid_lrw", 27'd0);
      tick();
      rst = 1'b1;
      #1;
      check("rst_release_f0", PCO | MAR | PCI);

      // Stalled fetch: MFC held low in FRW
      tick();
      check("to_frw1", MEN | MRW);
`ifdef CTRL_MFC_TIMEOUT_EN
      repeat (14) tick();
      check("to_frw15", MEN | MRW);
      tick();
      check("to_flt", FLT);
      repeat (5) tick();
      check("to_flt_hold", FLT);
`else
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (strobes !== (MEN | MRW)) bad++;
      end
      check_int("frw_hold_bad_cycles", bad, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
